padovan_checker: RTL and testbench
==================================

// Module: padovan_checker
// PURPOSE
//   Consumer side of the Padovan term stream. Accepts one W-bit term per handshake and checks it
//   against the recurrence P(0)=P(1)=P(2)=1, P(n)=P(n-2)+P(n-3).
//   Reports a per-term pass/fail with the term index, and flags end-of-sequence when the next
//   expected term no longer fits in W bits.
//   Sits downstream of the sequence generator as a self-check and monitor block.
// PARAMETERS
//   W      16  term width in bits (in_data, expected-term registers)
//   IDX_W  16  index counter width (chk_idx, err_idx)
// PORTS
//   clk       in   1      single clock; all state updates on its rising edge
//   rst       in   1      synchronous, active-high reset
//   clr       in   1      synchronous restart to the seed state; errors and end flag cleared
//   in_valid  in   1      term present on in_data
//   in_data   in   W      received term
//   in_ready  out  1      block can accept a term this cycle
//   chk_valid out  1      one-cycle pulse: result of the previous accepted term
//   chk_ok    out  1      term matched the expected value (qualified by chk_valid)
//   chk_idx   out  IDX_W  index n of the term just checked
//   err       out  1      sticky: at least one mismatch since rst/clr
//   err_idx   out  IDX_W  index of the first mismatch; held while err=1
//   seq_end   out  1      sticky: next expected term overflows W bits
// BEHAVIOUR
//   - Reset (rst=1): state=TRACK, idx=0, seed history = 1,1,1.
//     Output reset values: in_ready=1, chk_valid=0, chk_ok=0, chk_idx=0, err=0, err_idx=0, seq_end=0.
//   - Accept: a term is accepted when in_valid & in_ready.
//     Result appears the next cycle: chk_valid=1, chk_ok=(in_data==exp), chk_idx=idx.
//     Latency is 1 cycle. No result is produced without an accept.
//   - Expected value: exp = 1 for idx 0..2. For idx>=3, exp = p2+p3 over the last three
//     *expected* values (not the received values), so one bad term does not corrupt later checks.
//   - Per accept: shift history p3<=p2, p2<=p1, p1<=exp; idx<=idx+1.
//   - Next-term sum is computed W+1 bits wide. If bit W is set after an accept, seq_end<=1 and
//     state<=END. exp is never truncated.
//   - States:
//       TRACK: in_ready=1.
//              On mismatch: err<=1, and err_idx<=idx only if err was 0. Stays in TRACK.
//       END:   in_ready=0; no further accepts; outputs held.
//     Transitions: TRACK->END on overflow; END->TRACK only via rst or clr.
//   - chk_ok on the last accepted term (the one that triggers seq_end) is still reported normally.
//   - clr: behaves exactly like rst for all state and outputs.
//     clr with in_valid the same cycle: clr wins, the term is dropped, chk_valid=0 next cycle.
//   - rst or clr mid-stream: the pending chk_valid pulse is suppressed.
//   - Index counter saturates at 2^IDX_W-1; it never wraps.
//   - in_valid while in_ready=0: ignored; no side effects.
// STRUCTURE
//   Shared package padovan_pkg holds:
//     - state enum {TRACK, END}
//     - localparam SEED = 1
//     - localparam SEED_TERMS = 3
//   Both the generator and this checker use that package.
//   One sub-module, padovan_next: holds the p1/p2/p3 history and idx; outputs exp and ovf
//   (W+1-bit sum carry); takes advance and restart inputs.
//   The top level holds the FSM, compare logic and result registers.
// TESTING
//   1. W=8, feed 1,1,1,2,2,3,4,5,7,9,12 back-to-back
//      -> 11 chk_valid pulses, all chk_ok=1, chk_idx 0..10, err=0.
//   2. W=8, full correct stream up to 200 (idx 20)
//      -> idx 20 chk_ok=1, then seq_end=1, in_ready=0 next cycle; in_valid later gives no chk_valid.
//   3. W=16, full correct stream through 55405 (idx 40)
//      -> seq_end=1 after idx 40; 41 passes total.
//   4. Stream 1,1,1,2,9,3,4 -> idx 4 chk_ok=0; err=1, err_idx=4; idx 5 (3) and idx 6 (4) chk_ok=1.
//   5. Second mismatch at idx 7 after test 4 -> err_idx remains 4.
//   6. Assert clr together with in_valid at idx 5
//      -> no chk_valid; err=0, seq_end=0; next term 1 is checked as idx 0 with chk_ok=1.

Source files
------------

// File: rtl/padovan_pkg.sv
// Shared definitions for the Padovan generator / checker pair.
package padovan_pkg;

  // Checker tracking state: TRACK accepts terms, END stops once the next term would overflow.
  typedef enum logic {
    TRACK = 1'b0,
    END   = 1'b1
  } state_e;

  // Value of the first SEED_TERMS terms of the sequence.
  localparam int SEED       = 1;
  localparam int SEED_TERMS = 3;

endpackage

// File: rtl/padovan_next.sv
// Expected-term tracker: holds the last three expected terms and the term index,
// produces the expected value for the current index and flags when the term after
// it no longer fits in W bits.
module padovan_next
  import padovan_pkg::*;
#(
  parameter int W     = 16,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_restart,
  input  logic             i_advance,
  output logic [W-1:0]     o_exp,
  output logic             o_ovf,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [W-1:0]     L_SEED       = W'(SEED);
  localparam logic [IDX_W-1:0] L_SEED_TERMS = IDX_W'(SEED_TERMS);
  localparam logic [IDX_W-1:0] L_IDX_MAX    = '1;

  // r_p1 is the most recent expected term, r_p3 the oldest of the three.
  logic [W-1:0]     r_p1;
  logic [W-1:0]     r_p2;
  logic [W-1:0]     r_p3;
  logic [IDX_W-1:0] r_idx;

  logic [W-1:0]     w_sum;

  // The history holds expected values only, so a bad received term never pollutes later checks.
  assign w_sum = r_p2 + r_p3;
  assign o_exp = (r_idx < L_SEED_TERMS) ? L_SEED : w_sum;
  assign o_idx = r_idx;

  // The term after the current one is r_p1 + r_p2. Its (W+1)-bit sum carries exactly
  // when r_p1 exceeds (2^W-1) - r_p2, which is ~r_p2, so the carry is taken from a compare.
  // For the seed indices this sum is 2, which cannot carry for W >= 2.
  assign o_ovf = (r_p1 > ~r_p2);

  // Shift the expected history on every accepted term; index saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_p1  <= L_SEED;
      r_p2  <= L_SEED;
      r_p3  <= L_SEED;
      r_idx <= '0;
    end else if (i_advance) begin
      r_p3 <= r_p2;
      r_p2 <= r_p1;
      r_p1 <= o_exp;
      if (r_idx != L_IDX_MAX) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/padovan_checker.sv
// Padovan stream checker: compares each accepted term against the recurrence,
// reports a per-term result one cycle later, keeps a sticky first-error index and
// stops accepting once the next expected term would not fit in W bits.
module padovan_checker
  import padovan_pkg::*;
#(
  parameter int W     = 16,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic [IDX_W-1:0] chk_idx,
  output logic             err,
  output logic [IDX_W-1:0] err_idx,
  output logic             seq_end
);

  state_e           r_state;
  state_e           w_state_next;

  logic             r_chk_valid;
  logic             r_chk_ok;
  logic [IDX_W-1:0] r_chk_idx;
  logic             r_err;
  logic [IDX_W-1:0] r_err_idx;
  logic             r_seq_end;

  logic             w_accept;
  logic             w_advance;
  logic             w_match;
  logic [W-1:0]     w_exp;
  logic             w_ovf;
  logic [IDX_W-1:0] w_idx;

  assign in_ready  = (r_state == TRACK);
  assign w_accept  = in_valid && in_ready;
  // clr wins over a same-cycle term: the term is dropped without touching the history.
  assign w_advance = w_accept && !clr;
  assign w_match   = (in_data == w_exp);

  padovan_next #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_next (
    .clk       (clk),
    .rst       (rst),
    .i_restart (clr),
    .i_advance (w_advance),
    .o_exp     (w_exp),
    .o_ovf     (w_ovf),
    .o_idx     (w_idx)
  );

  // Next-state: leave TRACK once an accepted term leaves no room for its successor.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TRACK:   if (w_accept && w_ovf) w_state_next = END;
      END:     w_state_next = END;
      default: w_state_next = TRACK;
    endcase
  end

  // State register; clr is a full restart just like rst.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= TRACK;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result, sticky error and end-of-sequence registers.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_chk_valid <= 1'b0;
      r_chk_ok    <= 1'b0;
      r_chk_idx   <= '0;
      r_err       <= 1'b0;
      r_err_idx   <= '0;
      r_seq_end   <= 1'b0;
    end else begin
      r_chk_valid <= w_accept;
      if (w_accept) begin
        r_chk_ok  <= w_match;
        r_chk_idx <= w_idx;
        if (!w_match) begin
          r_err <= 1'b1;
          if (!r_err) begin
            r_err_idx <= w_idx;
          end
        end
        if (w_ovf) begin
          r_seq_end <= 1'b1;
        end
      end
    end
  end

  assign chk_valid = r_chk_valid;
  assign chk_ok    = r_chk_ok;
  assign chk_idx   = r_chk_idx;
  assign err       = r_err;
  assign err_idx   = r_err_idx;
  assign seq_end   = r_seq_end;

endmodule

// File: tb/tb_padovan_checker.sv
// Bench for padovan_checker: an 8-bit and a 16-bit instance share one stimulus stream;
// a reference model built on a precomputed Padovan table is compared every cycle,
// and directed scenarios add literal checks.
module tb_padovan_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;

  logic [1:0]  o_ready, o_cv, o_ok, o_err, o_end;
  logic [15:0] o_cidx8, o_eidx8, o_cidx16, o_eidx16;

  int total = 0;
  int bad   = 0;

  logic [31:0] pad [64];
  bit          chk_en = 1'b0;

  // Observed-result counters (index 0 = 8-bit instance, 1 = 16-bit instance).
  int nv [2];
  int np [2];

  // Model state per instance.
  int width [2];
  int m_idx [2];
  bit m_end [2];
  bit m_err [2];
  int m_eidx [2];
  bit m_cv [2];
  bit m_ok [2];
  int m_cidx [2];

  always #5 clk = ~clk;

  padovan_checker #(.W(8), .IDX_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data[7:0]),
    .in_ready(o_ready[0]), .chk_valid(o_cv[0]), .chk_ok(o_ok[0]), .chk_idx(o_cidx8),
    .err(o_err[0]), .err_idx(o_eidx8), .seq_end(o_end[0])
  );

  padovan_checker #(.W(16), .IDX_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(o_ready[1]), .chk_valid(o_cv[1]), .chk_ok(o_ok[1]), .chk_idx(o_cidx16),
    .err(o_err[1]), .err_idx(o_eidx16), .seq_end(o_end[1])
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: advance on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || clr) begin
        m_idx[k] = 0; m_end[k] = 0; m_err[k] = 0; m_eidx[k] = 0;
        m_cv[k] = 0; m_ok[k] = 0; m_cidx[k] = 0;
      end else begin
        m_cv[k] = 0;
        if (in_valid && !m_end[k]) begin
          logic [31:0] d;
          d = (k == 0) ? {24'd0, in_data[7:0]} : {16'd0, in_data};
          m_cv[k]   = 1;
          m_ok[k]   = (d == pad[m_idx[k]]);
          m_cidx[k] = m_idx[k];
          if (!m_ok[k]) begin
            if (!m_err[k]) m_eidx[k] = m_idx[k];
            m_err[k] = 1;
          end
          if (m_idx[k] >= 62 || pad[m_idx[k] + 1] >= (32'd1 << width[k])) m_end[k] = 1;
          if (m_idx[k] < 65535) m_idx[k] = m_idx[k] + 1;
        end
      end
    end
    if (rst) chk_en = 1'b1;
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int cidx, eidx;
        cidx = (k == 0) ? int'(o_cidx8) : int'(o_cidx16);
        eidx = (k == 0) ? int'(o_eidx8) : int'(o_eidx16);
        chk($sformatf("in_ready[w%0d]", width[k]), o_ready[k], !m_end[k]);
        chk($sformatf("chk_valid[w%0d]", width[k]), o_cv[k], m_cv[k]);
        chk($sformatf("err[w%0d]", width[k]), o_err[k], m_err[k]);
        chk($sformatf("err_idx[w%0d]", width[k]), eidx, m_eidx[k]);
        chk($sformatf("seq_end[w%0d]", width[k]), o_end[k], m_end[k]);
        if (m_cv[k]) begin
          chk($sformatf("chk_ok[w%0d] idx%0d", width[k], m_cidx[k]), o_ok[k], m_ok[k]);
          chk($sformatf("chk_idx[w%0d]", width[k]), cidx, m_cidx[k]);
        end
        if (o_cv[k]) begin
          nv[k]++;
          if (o_ok[k]) np[k]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic zero_counts();
    nv[0] = 0; nv[1] = 0; np[0] = 0; np[1] = 0;
  endtask

  initial begin
    logic [15:0] seq1 [11];
    logic [15:0] seq4 [7];
    seq1 = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7, 16'd9, 16'd12};
    seq4 = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd9, 16'd3, 16'd4};
    width[0] = 8;
    width[1] = 16;
    pad[0] = 1; pad[1] = 1; pad[2] = 1;
    for (int i = 3; i < 64; i++) pad[i] = pad[i-2] + pad[i-3];
    zero_counts();

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    step();
    step();
    // Reset values.
    chk("reset in_ready", o_ready, 2'b11);
    chk("reset chk_valid", o_cv, 2'b00);
    chk("reset err", o_err, 2'b00);
    chk("reset seq_end", o_end, 2'b00);
    chk("reset chk_idx", o_cidx16, 0);
    chk("reset err_idx", o_eidx8, 0);
    rst = 1'b0;
    // Pin the reference table.
    chk("table P(10)", pad[10], 12);
    chk("table P(20)", pad[20], 200);
    chk("table P(40)", pad[40], 55405);
    chk("table P(41)", pad[41], 73396);
    step();

    // Test 1: first eleven terms back-to-back.
    zero_counts();
    for (int i = 0; i < 11; i++) send(seq1[i]);
    step();
    $display("test1: 11 terms, passes w8=%0d w16=%0d", np[0], np[1]);
    chk("t1 passes w8", np[0], 11);
    chk("t1 passes w16", np[1], 11);
    chk("t1 last idx", o_cidx16, 10);
    chk("t1 err", o_err, 2'b00);

    // Tests 2/3: full stream; 8-bit ends after idx 20, 16-bit after idx 40.
    do_clr();
    zero_counts();
    for (int i = 0; i < 41; i++) send(pad[i][15:0]);
    step();
    $display("test2/3: full stream, passes w8=%0d w16=%0d", np[0], np[1]);
    chk("t2 valids w8", nv[0], 21);
    chk("t2 passes w8", np[0], 21);
    chk("t3 passes w16", np[1], 41);
    chk("t3 seq_end", o_end, 2'b11);
    chk("t3 in_ready", o_ready, 2'b00);
    chk("t3 last idx", o_cidx16, 40);
    send(16'd1);
    step();
    $display("post-end term: valids w8=%0d w16=%0d", nv[0], nv[1]);
    chk("t3 no accept after end", nv[1], 41);

    // Test 4: mismatch at idx 4.
    do_clr();
    zero_counts();
    for (int i = 0; i < 7; i++) send(seq4[i]);
    step();
    $display("test4: err=%0d err_idx=%0d passes=%0d", o_err[1], o_eidx16, np[1]);
    chk("t4 err", o_err, 2'b11);
    chk("t4 err_idx", o_eidx16, 4);
    chk("t4 passes", np[1], 6);

    // Test 5: second mismatch at idx 7 keeps the first index.
    send(16'd0);
    step();
    $display("test5: err_idx=%0d chk_idx=%0d", o_eidx16, o_cidx16);
    chk("t5 err_idx", o_eidx16, 4);
    chk("t5 chk_idx", o_cidx16, 7);
    chk("t5 valids", nv[1], 8);

    // Test 6: clr together with in_valid at idx 5.
    do_clr();
    for (int i = 0; i < 5; i++) send(seq4[i]);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'd3;
    step();
    clr = 1'b0; in_valid = 1'b0;
    $display("test6: after clr chk_valid=%0d err=%0d", o_cv[1], o_err[1]);
    chk("t6 chk_valid", o_cv, 2'b00);
    chk("t6 err", o_err, 2'b00);
    chk("t6 seq_end", o_end, 2'b00);
    send(16'd1);
    $display("test6: restart term chk_idx=%0d ok=%0d", o_cidx16, o_ok[1]);
    chk("t6 restart valid", o_cv[1], 1);
    chk("t6 restart ok", o_ok[1], 1);
    chk("t6 restart idx", o_cidx16, 0);

    // Gapped stream with a bad term, then rst alongside a valid term.
    for (int i = 1; i < 9; i++) begin
      send((i == 6) ? 16'd99 : pad[i][15:0]);
      if (i % 3 == 0) step();
    end
    step();
    $display("gapped: err_idx=%0d chk_idx=%0d", o_eidx16, o_cidx16);
    chk("gap err_idx", o_eidx16, 6);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'd9;
    step();
    rst = 1'b0; in_valid = 1'b0;
    $display("rst with term: chk_valid=%0d", o_cv[1]);
    chk("rst drop valid", o_cv, 2'b00);
    chk("rst drop err", o_err, 2'b00);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
